// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory end of the CPU fetch interface. A program image is
//   streamed in byte-serially (little-endian within each word) through the
//   load port. The CPU's fetch address PC_i is then answered with the stored
//   32-bit word one cycle later.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   NOP_INSN     word returned when there is no valid fetch
//
// Ports
//   clk, rst      single clock; synchronous active-high reset
//   PC_i          fetch byte address
//   ins           registered fetch result
//   ins_valid     ins is the result for the PC_i of the previous cycle
//   fault         previous-cycle PC_i misaligned or out of range
//   ld_start      pulse: begin a program load
//   ld_valid      ld_byte is presented
//   ld_byte       program byte
//   ld_last       ld_byte is the final byte of the image
//   ld_ready      byte accepted when ld_valid & ld_ready (high only while loading)
//   ld_done       one-cycle pulse when a load completes
//   ld_overflow   sticky: last load ended because memory filled
//   ld_word_cnt   words written by the current / last load
// ----------------------------------------------------------------------------
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  PC_i,
   output logic [31:0]                  ins,
   output logic                         ins_valid,
   output logic                         fault,
   input  logic                         ld_start,
   input  logic                         ld_valid,
   input  logic [7:0]                   ld_byte,
   input  logic                         ld_last,
   output logic                         ld_ready,
   output logic                         ld_done,
   output logic                         ld_overflow,
   output logic [$clog2(DEPTH_WORDS):0] ld_word_cnt
);

   localparam int            AW        = $clog2(DEPTH_WORDS);
   localparam int            CW        = AW + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);
   localparam logic [31:0]   DEPTH_32  = 32'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_lane;
   logic [31:0]   r_asm;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic          r_done;
   logic [31:0]   r_ins_p1;
   logic          r_vld_p1;
   logic          r_fault_p1;

   // Words are stored XORed with NOP_INSN so that an all-zero power-up image
   // (the default content of block RAM) reads back as NOP_INSN. The array is
   // deliberately never cleared by rst.
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_acc;
   logic          w_wr;
   logic          w_load_end;
   logic          w_run_hold;
   logic [31:0]   w_word;
   logic [CW-1:0] w_cnt_inc;
   logic [31:0]   w_off;
   logic [31:0]   w_idx32;
   logic          w_oor;
   logic          w_bad;
   logic [AW-1:0] w_rd_idx;

   // FSM next state and load-path decode
   always_comb begin
      w_state_nxt = r_state;
      w_acc       = (r_state == S_LOAD) && ld_valid;
      w_word      = r_asm | ({24'd0, ld_byte} << {r_lane, 3'b000});
      w_cnt_inc   = r_cnt + CW'(1);
      // A word is committed on the fourth byte or early on the image's last byte
      w_wr        = w_acc && ((r_lane == 2'd3) || ld_last);
      w_load_end  = w_wr && (ld_last || (w_cnt_inc == DEPTH_CNT));

      case (r_state)
         S_IDLE:  if (ld_start)   w_state_nxt = S_LOAD;
         S_LOAD:  if (w_load_end) w_state_nxt = S_RUN;
         S_RUN:   if (ld_start)   w_state_nxt = S_LOAD;
         default:                 w_state_nxt = S_IDLE;
      endcase

      // A fetch result is only meaningful when RUN was active at the sampling
      // edge and is not being left for a new load.
      w_run_hold  = (r_state == S_RUN) && (w_state_nxt == S_RUN);
   end

   // Fetch address decode (unsigned 32-bit, no wrap)
   always_comb begin
      w_off    = PC_i - BASE_ADDR;
      w_idx32  = w_off >> 2;
      w_oor    = (PC_i < BASE_ADDR) || (w_idx32 >= DEPTH_32);
      w_bad    = w_oor || (PC_i[1:0] != 2'b00);
      w_rd_idx = w_idx32[AW-1:0];
   end

   // Control state and load bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lane  <= 2'd0;
         r_asm   <= 32'd0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if ((r_state != S_LOAD) && ld_start) begin
            r_lane <= 2'd0;
            r_asm  <= 32'd0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
         end else if (w_acc) begin
            if (w_wr) begin
               r_lane <= 2'd0;
               r_asm  <= 32'd0;
               r_cnt  <= w_cnt_inc;
               if (ld_last) begin
                  r_done <= 1'b1;
               end else if (w_cnt_inc == DEPTH_CNT) begin
                  r_done <= 1'b1;
                  r_ovf  <= 1'b1;
               end
            end else begin
               r_asm  <= w_word;
               r_lane <= r_lane + 2'd1;
            end
         end
      end
   end

   // Memory write port (load path only)
   always_ff @(posedge clk) begin
      if (w_wr && !rst) begin
         r_mem[r_cnt[AW-1:0]] <= w_word ^ NOP_INSN;
      end
   end

   // ---- stage p0 -> p1: PC_i sampled, fetch result presented next cycle ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ins_p1   <= NOP_INSN;
         r_vld_p1   <= 1'b0;
         r_fault_p1 <= 1'b0;
      end else begin
         r_vld_p1   <= w_run_hold;
         r_fault_p1 <= w_run_hold && w_bad;
         r_ins_p1   <= (w_run_hold && !w_bad) ? (r_mem[w_rd_idx] ^ NOP_INSN) : NOP_INSN;
      end
   end

   assign ins         = r_ins_p1;
   assign ins_valid   = r_vld_p1;
   assign fault       = r_fault_p1;
   assign ld_ready    = (r_state == S_LOAD);
   assign ld_done     = r_done;
   assign ld_overflow = r_ovf;
   assign ld_word_cnt = r_cnt;

endmodule
